// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding and frame defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_SB_TICK    = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, resets to 1 (idle line level).
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronized out).
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling; frames reassembled LSB-first, one done strobe per frame.
// Latency: done pulse at mid stop bit (2-cycle input sync plus 1 register stage).
// Backpressure: none; each byte is presented once and must be taken in the done cycle.
// Ports: CLK_100MHZ, reset (sync, active-high), tick (oversample strobe), rx (async line),
//        dout (last byte), rx_done_tick (1-cycle valid), frame_error (stop sampled low), busy.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 CLK_100MHZ,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 frame_error,
    output logic                 busy
);

    // s must also reach OVERSAMPLE-1 in DATA, so size it for the larger of the two limits.
    localparam int S_W = $clog2(max_int(SB_TICK, OVERSAMPLE));
    localparam int N_W = $clog2(DATA_BITS);

    localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    uart_state_t          state;
    logic [S_W-1:0]       s;
    logic [N_W-1:0]       n;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s;
    logic                 rx_prev;

    sync_2ff u_sync_rx (
        .clk   (CLK_100MHZ),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge CLK_100MHZ) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            shift        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_error  <= 1'b0;
            rx_prev      <= 1'b1;
        end else begin
            rx_prev      <= rx_s;
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    // Edge, not level: a held-low line (break) cannot re-arm until it goes high.
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == S_HALF) begin
                            s <= '0;
                            n <= '0;
                            // Still low at mid start bit: real frame; later samples land mid-bit.
                            state <= rx_s ? IDLE : DATA;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            shift <= {rx_s, shift[DATA_BITS-1:1]};
                            if (n == N_LAST) begin
                                n     <= '0;
                                state <= STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == S_STOP) begin
                            s            <= '0;
                            dout         <= shift;
                            frame_error  <= ~rx_s;
                            rx_done_tick <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    s     <= '0;
                    n     <= '0;
                end
            endcase
        end
    end

endmodule
